// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone B4 pipelined master. A single burst command (address, direction,
// length) becomes a run of single-beat transfers at incrementing addresses.
// Write words come from a valid/ready stream. Read words leave on a
// valid-only stream. Stall back-pressure is honoured, outstanding acks are
// counted, and the burst is aborted with an error if acks stop arriving.
//
// Ports
//   wb_clock_i, wb_reset_ni         clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake
//   cmd_addr_i, cmd_we_i, cmd_len_i first address, direction, beats minus one
//   wr_valid_i / wr_ready_o         write data stream, wr_data_i
//   rd_valid_o, rd_data_o           read data stream (one-cycle pulses)
//   done_o, err_o                   end-of-burst pulse, err_o = timed out
//   wb_*                            Wishbone pipelined master interface
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released, waiting for a command
// ISSUE | cycle open, loading and transferring beats
// DRAIN | every beat transferred, waiting for the remaining acks
// ---------------------------------------------------------------------------
module wb_burst_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_we_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_we_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i
);

    localparam int CW = LEN_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT);
    // Down-counter reload: terminal count (0) is reached TIMEOUT-1 idle
    // cycles after a reload, and the abort fires on the following edge.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [CW-1:0]         beats_q;     // beats not yet loaded onto the bus
    logic [CW-1:0]         outst_q;     // transferred beats awaiting ack
    logic [CW-1:0]         outst_d;
    logic [TW-1:0]         tmo_q;

    logic busy;
    logic xfer;
    logic ack_eff;
    logic accept;
    logic load;
    logic wait_wr;
    logic finish;
    logic abort;
    logic tmo_clr;

    assign busy    = (state_q != IDLE);
    assign xfer    = wb_strobe_o && !wb_stall_i;
    // Acks with nothing outstanding (stray, or after an abort) are dropped.
    assign ack_eff = wb_ack_i && busy && (outst_q != '0);
    assign outst_d = outst_q + CW'(xfer) - CW'(ack_eff);

    assign cmd_ready_o = (state_q == IDLE) && wb_reset_ni;
    assign wr_ready_o  = load && wb_we_o && wb_reset_ni;

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        wait_wr = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        tmo_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (beats_q != '0) begin
                    wait_wr = wb_we_o && !wr_valid_i;
                    load    = (!wb_strobe_o || !wb_stall_i) && !wait_wr;
                end else if (xfer) begin
                    if (outst_d == '0) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: any bus progress or a stall on the write stream counts
        // as activity; otherwise the counter runs down to an abort.
        if (busy && !finish) begin
            tmo_clr = xfer || ack_eff || wait_wr;
            if (!tmo_clr && (tmo_q == '0)) begin
                abort   = 1'b1;
                load    = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            next_addr_q <= '0;
            beats_q     <= '0;
            outst_q     <= '0;
            tmo_q       <= '0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_we_o     <= 1'b0;
            wb_cycle_o  <= 1'b0;
            wb_strobe_o <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_valid_o <= 1'b0;

            if (accept) begin
                next_addr_q <= cmd_addr_i;
                beats_q     <= CW'(cmd_len_i) + CW'(1);
                wb_we_o     <= cmd_we_i;
                wb_cycle_o  <= 1'b1;
                outst_q     <= '0;
                tmo_q       <= TMO_LOAD;
            end

            if (busy) begin
                outst_q <= outst_d;
                if (tmo_clr) begin
                    tmo_q <= TMO_LOAD;
                end else if (tmo_q != '0) begin
                    tmo_q <= tmo_q - TW'(1);
                end
            end

            if (load) begin
                wb_strobe_o <= 1'b1;
                wb_addr_o   <= next_addr_q;
                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                beats_q     <= beats_q - CW'(1);
                if (wb_we_o) begin
                    wb_data_o <= wr_data_i;
                end
            end else if (xfer) begin
                wb_strobe_o <= 1'b0;
            end

            if (ack_eff && !wb_we_o) begin
                rd_valid_o <= 1'b1;
                rd_data_o  <= wb_data_i;
            end

            if (finish || abort) begin
                wb_cycle_o  <= 1'b0;
                wb_strobe_o <= 1'b0;
                wb_we_o     <= 1'b0;
                outst_q     <= '0;
                beats_q     <= '0;
                done_o      <= 1'b1;
                err_o       <= abort;
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_addr;
    logic       cmd_we;
    logic [7:0] cmd_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done;
    logic       err;
    logic [9:0] wb_addr;
    logic [7:0] wb_wdat;
    logic [7:0] wb_rdat;
    logic       wb_we;
    logic       wb_cyc;
    logic       wb_stb;
    logic       stall;
    logic       wb_ack;

    logic       ack_en;
    logic       late_ack;
    logic       slv_ack;
    logic [7:0] mem [0:1023];
    logic [7:0] wr_vec [0:7];
    logic [2:0] wr_idx = 3'd0;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int wr_rdy_cnt = 0;
    logic [7:0] rd_buf [0:63];

    always #5 clk = ~clk;

    wb_burst_master #(
        .ADDR_WIDTH(10), .DATA_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT(255)
    ) dut (
        .wb_clock_i (clk),
        .wb_reset_ni(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_addr_i (cmd_addr),
        .cmd_we_i   (cmd_we),
        .cmd_len_i  (cmd_len),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .done_o     (done),
        .err_o      (err),
        .wb_addr_o  (wb_addr),
        .wb_data_o  (wb_wdat),
        .wb_data_i  (wb_rdat),
        .wb_we_o    (wb_we),
        .wb_cycle_o (wb_cyc),
        .wb_strobe_o(wb_stb),
        .wb_stall_i (stall),
        .wb_ack_i   (wb_ack)
    );

    // Block RAM slave: registered read data and ack, contents re-seeded on
    // reset so that mem[a] = 0xA0 ^ a[7:0].
    assign wb_ack = slv_ack | late_ack;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'hA0 ^ i[7:0];
            slv_ack <= 1'b0;
            wb_rdat <= 8'h00;
        end else begin
            slv_ack <= ack_en && wb_cyc && wb_stb && !stall;
            if (wb_cyc && wb_stb && !stall) begin
                if (wb_we) mem[wb_addr] <= wb_wdat;
                wb_rdat <= mem[wb_addr];
            end
        end
    end

    assign wr_data = wr_vec[wr_idx];
    always @(posedge clk) if (wr_valid && wr_ready) wr_idx <= wr_idx + 3'd1;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_buf[rd_cnt[5:0]] <= rd_data;
            rd_cnt <= rd_cnt + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (wr_ready === 1'b1) wr_rdy_cnt <= wr_rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max, input logic exp_err);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " err"}, err, exp_err);
    endtask

    task automatic send_cmd(input logic [9:0] a, input logic we, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_we    = we;
        cmd_len   = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int w0;
        int n;
        int early;
        logic [9:0] ea;

        wr_vec[0] = 8'h11; wr_vec[1] = 8'h22; wr_vec[2] = 8'h33; wr_vec[3] = 8'h44;
        wr_vec[4] = 8'hAB; wr_vec[5] = 8'hCD; wr_vec[6] = 8'h00; wr_vec[7] = 8'h00;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_len = '0;
        wr_valid = 1'b0; stall = 1'b0; ack_en = 1'b1; late_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst cyc", wb_cyc, 0);
        chk("rst stb", wb_stb, 0);
        chk("rst addr", wb_addr, 0);
        chk("rst done", done, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst cmd_ready released", cmd_ready, 1);

        // 1: single read, len 0, addr 0x005
        send_cmd(10'h005, 1'b0, 8'd0);
        #1;
        chk("t1 cmd_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b0;
        chk("t1 cyc after accept", wb_cyc, 1);
        chk("t1 stb after accept", wb_stb, 0);
        tick();
        chk("t1 stb", wb_stb, 1);
        chk("t1 addr", wb_addr, 10'h005);
        tick();
        chk("t1 stb dropped", wb_stb, 0);
        chk("t1 no early done", done, 0);
        tick();
        chk("t1 rd_valid", rd_valid, 1);
        chk("t1 rd_data", rd_data, 8'hA5);
        chk("t1 done", done, 1);
        chk("t1 err", err, 0);
        chk("t1 cyc low", wb_cyc, 0);
        tick();
        chk("t1 done pulse", done, 0);
        chk("t1 ready again", cmd_ready, 1);

        // 2: write burst len 3 across the address wrap
        w0 = wr_rdy_cnt;
        wr_valid = 1'b1;
        send_cmd(10'h3FE, 1'b1, 8'd3);
        tick(); cmd_valid = 1'b0;
        #1;
        chk("t2 wr_ready first", wr_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            ea = 10'h3FE + 10'(k);
            chk($sformatf("t2 addr%0d", k), wb_addr, ea);
            chk($sformatf("t2 data%0d", k), wb_wdat, wr_vec[k]);
            chk($sformatf("t2 stb%0d", k), wb_stb, 1);
            chk($sformatf("t2 wr_ready%0d", k), wr_ready, (k < 3) ? 1 : 0);
        end
        wr_valid = 1'b0;
        wait_done("t2", 20, 1'b0);
        tick();
        chk("t2 wr_ready cycles", wr_rdy_cnt - w0, 4);
        r0 = rd_cnt;
        send_cmd(10'h3FE, 1'b0, 8'd3);
        tick(); cmd_valid = 1'b0;
        wait_done("t2 readback", 20, 1'b0);
        tick();
        chk("t2 readback count", rd_cnt - r0, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2 readback%0d", k), rd_buf[r0 + k], wr_vec[k]);

        // 3: read burst len 7 with a 3-cycle stall on beat 2
        r0 = rd_cnt; d0 = done_cnt;
        send_cmd(10'h100, 1'b0, 8'd7);
        tick(); cmd_valid = 1'b0;
        n = 0;
        while (!(wb_stb === 1'b1 && wb_addr === 10'h102) && n < 20) begin
            tick();
            n++;
        end
        chk("t3 beat2 presented", (wb_stb === 1'b1 && wb_addr === 10'h102), 1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t3 hold addr%0d", k), wb_addr, 10'h102);
            chk($sformatf("t3 hold stb%0d", k), wb_stb, 1);
        end
        stall = 1'b0;
        wait_done("t3", 40, 1'b0);
        tick(); tick();
        chk("t3 rd count", rd_cnt - r0, 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3 rd%0d", k), rd_buf[r0 + k], 8'hA0 ^ 8'(k));
        chk("t3 single done", done_cnt - d0, 1);

        // 4: write len 1 with a 5-cycle gap in write data
        wr_valid = 1'b1;
        send_cmd(10'h050, 1'b1, 8'd1);
        tick(); cmd_valid = 1'b0;
        #1;
        chk("t4 wr_ready first", wr_ready, 1);
        tick();
        chk("t4 addr0", wb_addr, 10'h050);
        chk("t4 data0", wb_wdat, 8'hAB);
        wr_valid = 1'b0;
        #1;
        chk("t4 wr_ready gap", wr_ready, 0);
        early = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t4 gap stb%0d", k), wb_stb, 0);
            chk($sformatf("t4 gap cyc%0d", k), wb_cyc, 1);
            if (done === 1'b1) early++;
        end
        chk("t4 no done in gap", early, 0);
        wr_valid = 1'b1;
        #1;
        chk("t4 wr_ready resume", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        chk("t4 addr1", wb_addr, 10'h051);
        chk("t4 data1", wb_wdat, 8'hCD);
        wait_done("t4", 20, 1'b0);
        tick();
        chk("t4 mem50", mem[10'h050], 8'hAB);
        chk("t4 mem51", mem[10'h051], 8'hCD);

        // 5: no ack -> timeout 255 cycles after the last transfer
        ack_en = 1'b0;
        r0 = rd_cnt;
        send_cmd(10'h010, 1'b0, 8'd0);
        tick(); cmd_valid = 1'b0;
        tick();
        chk("t5 stb", wb_stb, 1);
        tick();
        chk("t5 transferred", wb_stb, 0);
        early = 0;
        for (int i = 1; i < 255; i++) begin
            tick();
            if (done === 1'b1) early++;
        end
        chk("t5 no early done", early, 0);
        chk("t5 cyc before abort", wb_cyc, 1);
        tick();
        chk("t5 done", done, 1);
        chk("t5 err", err, 1);
        chk("t5 cyc", wb_cyc, 0);
        chk("t5 stb", wb_stb, 0);
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        tick(); tick();
        chk("t5 late ack ignored", rd_cnt - r0, 0);
        chk("t5 err idle", err, 0);
        ack_en = 1'b1;

        // 6: reset mid-burst, then an immediate new command
        d0 = done_cnt;
        send_cmd(10'h200, 1'b0, 8'd15);
        tick(); cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t6 mid burst cyc", wb_cyc, 1);
        rst_n = 1'b0;
        #1;
        chk("t6 cmd_ready in reset", cmd_ready, 0);
        chk("t6 wr_ready in reset", wr_ready, 0);
        tick();
        chk("t6 rst cyc", wb_cyc, 0);
        chk("t6 rst stb", wb_stb, 0);
        chk("t6 rst addr", wb_addr, 0);
        chk("t6 rst wdat", wb_wdat, 0);
        chk("t6 rst we", wb_we, 0);
        chk("t6 rst rd_valid", rd_valid, 0);
        chk("t6 rst rd_data", rd_data, 0);
        chk("t6 rst done", done, 0);
        chk("t6 rst err", err, 0);
        rst_n = 1'b1;
        send_cmd(10'h005, 1'b0, 8'd0);
        #1;
        chk("t6 ready after reset", cmd_ready, 1);
        tick(); cmd_valid = 1'b0;
        chk("t6 accepted", wb_cyc, 1);
        wait_done("t6", 20, 1'b0);
        chk("t6 rd_data", rd_data, 8'hA5);
        tick();
        chk("t6 only new done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone B4 pipelined master that sits directly upstream of the on-chip block RAM and other Wishbone peripherals.
- Turns a single burst command into consecutive single-beat bus transfers at incrementing addresses.
- Write data is pulled from a valid/ready stream; read data is pushed to a valid-only stream.
- Handles stall back-pressure and outstanding-ack counting, and aborts with an error if a peripheral never acknowledges.

Parameters:
ADDR_WIDTH, 10, width of wb_addr_o and cmd_addr_i
DATA_WIDTH, 8, width of the data buses
LEN_WIDTH, 8, width of cmd_len_i; burst length = cmd_len_i + 1 beats (1..2^LEN_WIDTH)
TIMEOUT, 255, cycles without ack progress before abort (>= 2)

Ports:
wb_clock_i  in  1  sole clock, rising edge
wb_reset_ni  in  1  synchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid && ready
cmd_addr_i  in  ADDR_WIDTH  first beat address
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_len_i  in  LEN_WIDTH  beats minus one
wr_valid_i  in  1  write data available
wr_data_i  in  DATA_WIDTH  write data
wr_ready_o  out  1  write word consumed this cycle
rd_valid_o  out  1  one-cycle pulse, read word valid
rd_data_o  out  DATA_WIDTH  read word
done_o  out  1  one-cycle pulse, burst finished
err_o  out  1  qualifies done_o; 1 = aborted by timeout
wb_addr_o  out  ADDR_WIDTH  bus address
wb_data_o  out  DATA_WIDTH  bus write data
wb_data_i  in  DATA_WIDTH  bus read data
wb_we_o  out  1  bus write enable
wb_cycle_o  out  1  bus cycle
wb_strobe_o  out  1  bus strobe
wb_stall_i  in  1  peripheral stall
wb_ack_i  in  1  peripheral ack

Behaviour:
- Reset: all registered outputs are 0 on the edge where wb_reset_ni=0. State goes to IDLE and counters clear. Reset mid-burst abandons the burst immediately with no done_o. cmd_ready_o and wr_ready_o are 0 while reset is held.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch addr, we and beats = len+1.
  - Set wb_cycle_o=1 and wb_we_o=cmd_we_i, then go to ISSUE.
- Beat issue:
  - A beat transfers on an edge where wb_strobe_o=1 and wb_stall_i=0.
  - A new beat loads (wb_strobe_o<=1, wb_addr_o, wb_data_o) when all of the following hold: in ISSUE, beats left to load > 0, (wb_strobe_o=0 or wb_stall_i=0), and (read or wr_valid_i=1).
  - wr_ready_o equals that load condition for writes (combinational); it is 0 for reads.
  - Back-to-back beats are sustained at 1 per cycle with no stall.
- Strobe rules:
  - wb_strobe_o drops when a beat transfers and no new beat loads.
  - While stalled, wb_addr_o, wb_data_o and wb_strobe_o hold.
- Address arithmetic: each loaded beat uses the previous address + 1, modulo 2^ADDR_WIDTH (wraps to 0).
- Write underflow: if wr_valid_i=0 mid-burst, wb_strobe_o is 0 while waiting; wb_cycle_o stays 1.
- Outstanding counter: width LEN_WIDTH+1.
  - +1 on transfer, -1 on wb_ack_i; both in one cycle means no change.
  - wb_ack_i while outstanding=0 is ignored.
- ISSUE to DRAIN: once all beats are loaded and the last one has transferred.
- DRAIN exit: when outstanding reaches 0 (including an ack in the same cycle as the last transfer):
  - wb_cycle_o<=0 and done_o<=1 on the same edge.
  - Return to IDLE, with cmd_ready_o=1 the following cycle.
- Reads: on each wb_ack_i during a read burst, rd_data_o<=wb_data_i and rd_valid_o<=1 (1-cycle latency). There is no back-pressure; the consumer must accept.
- Timeout:
  - Counter clears on any transfer, any ack, or any wait for write data.
  - Otherwise it increments in ISSUE/DRAIN.
  - On reaching TIMEOUT: wb_cycle_o and wb_strobe_o drop, done_o=err_o=1 for one cycle, state goes to IDLE.
  - Acks after an abort are ignored.
- err_o is 0 whenever done_o is 0.

Test Plan:
- Single read, len=0, addr=0x005, RAM[5]=0xA5, 1-cycle ack, no stall: accept at cycle 0; cyc/stb high at cycle 1 with addr 0x005; ack at cycle 2; rd_valid_o=1 and rd_data_o=0xA5 with done_o=1, err_o=0 at cycle 3; wb_cycle_o=0 at cycle 3.
- Write burst len=3 at addr 0x3FE, data 11,22,33,44 always valid: addresses 0x3FE,0x3FF,0x000,0x001 on 4 consecutive cycles; wr_ready_o high 4 cycles; RAM read-back matches.
- Read burst len=7 with wb_stall_i high for 3 cycles on beat 2: addr/strobe hold for 3 cycles; 8 rd_valid_o pulses in address order; exactly one done_o.
- Write burst len=1 with wr_valid_i low 5 cycles between words: strobe low during the gap, wb_cycle_o stays high, no timeout, done_o with err_o=0.
- Peripheral never acks, TIMEOUT=255: done_o=err_o=1 exactly 255 cycles after the last transfer; wb_cycle_o=0; a late ack produces no rd_valid_o.
- wb_reset_ni low for one cycle mid-burst of len=15: all outputs 0 next edge, no done_o; a new command is accepted immediately after reset releases.
